// File: rtl/reg_bank_wr16.sv
// reg_bank_wr16: write side of the 16 x W ARM register bank with PC fetch port and written-since-reset tracking
// Define REG_BANK_LINK_EN to add the BL link port (lr_wr_en/lr_data) writing R14.
module reg_bank_wr16 #(
  parameter int W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [3:0]      wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic            pc_wr_en,
  input  logic [W-1:0]    pc_in,
`ifdef REG_BANK_LINK_EN
  input  logic            lr_wr_en,
  input  logic [W-1:0]    lr_data,
`endif
  output logic [16*W-1:0] regs_flat,
  output logic [W-1:0]    pc,
  output logic [15:0]     reg_valid,
  output logic            wr_done,
  output logic [3:0]      wr_addr_q
);
  logic [W-1:0] regs [16];
  logic [W-1:0] wdat [16];
  logic [15:0]  gen_sel, wr_sel;
  logic         lr_req;
  logic [W-1:0] lr_val;
`ifdef REG_BANK_LINK_EN
  assign lr_req = lr_wr_en;
  assign lr_val = lr_data;
`else
  assign lr_req = 1'b0;
  assign lr_val = '0;
`endif
  // general port wins any collision on R14/R15
  always_comb begin
    gen_sel = wr_en ? (16'd1 << wr_addr) : 16'd0;
    wr_sel  = gen_sel | {pc_wr_en, lr_req, 14'd0};
    for (int i = 0; i < 16; i++) wdat[i] = wr_data;
    wdat[14] = gen_sel[14] ? wr_data : lr_val;
    wdat[15] = gen_sel[15] ? wr_data : pc_in;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs      <= '{default: '0};
      reg_valid <= '0;
      wr_done   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (wr_sel[i]) regs[i] <= wdat[i];
      reg_valid <= reg_valid | wr_sel;
      wr_done   <= wr_en;
      if (wr_en) wr_addr_q <= wr_addr;
    end
  end
  for (genvar n = 0; n < 16; n++) begin : g_flat
    assign regs_flat[n*W +: W] = regs[n];
  end
  assign pc = regs[15];
endmodule

// File: tb/tb_reg_bank_wr16.sv
// tb_reg_bank_wr16: directed scoreboard bench for reg_bank_wr16
module tb_reg_bank_wr16;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, wr_en = 0, pc_wr_en = 0;
  logic [3:0] wr_addr = 0;
  logic [W-1:0] wr_data = 0, pc_in = 0;
  logic lr_wr_en = 0;
  logic [W-1:0] lr_data = 0;
  logic [16*W-1:0] regs_flat;
  logic [W-1:0] pc;
  logic [15:0] reg_valid;
  logic wr_done;
  logic [3:0] wr_addr_q;

  reg_bank_wr16 #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_wr_en(pc_wr_en), .pc_in(pc_in),
`ifdef REG_BANK_LINK_EN
    .lr_wr_en(lr_wr_en), .lr_data(lr_data),
`endif
    .regs_flat(regs_flat), .pc(pc), .reg_valid(reg_valid), .wr_done(wr_done), .wr_addr_q(wr_addr_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [16*W-1:0] regs;
    logic [15:0] vld;
    logic done;
    logic [3:0] aq;
  } exp_t;

  exp_t sb[$];
  int compared = 0, mismatched = 0;
  logic [W-1:0] er [16];
  logic [15:0] ev = 0;
  logic ed = 0;
  logic [3:0] ea = 0;

  task automatic push(input string nm);
    exp_t e;
    e.name = nm;
    for (int i = 0; i < 16; i++) e.regs[i*W +: W] = er[i];
    e.vld = ev;
    e.done = ed;
    e.aq = ea;
    sb.push_back(e);
  endtask

  task automatic cyc(input string nm, input bit rn, input bit we, input logic [3:0] a,
                     input logic [W-1:0] d, input bit pe, input logic [W-1:0] p,
                     input bit le, input logic [W-1:0] l);
    @(negedge clk);
    rst_n = rn; wr_en = we; wr_addr = a; wr_data = d;
    pc_wr_en = pe; pc_in = p; lr_wr_en = le; lr_data = l;
    @(posedge clk);
    push(nm);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compared += 5;
      if (regs_flat !== e.regs) begin mismatched++; $display("FAIL %s regs_flat: got %h want %h", e.name, regs_flat, e.regs); end
      if (pc !== e.regs[15*W +: W]) begin mismatched++; $display("FAIL %s pc: got %h want %h", e.name, pc, e.regs[15*W +: W]); end
      if (reg_valid !== e.vld) begin mismatched++; $display("FAIL %s reg_valid: got %h want %h", e.name, reg_valid, e.vld); end
      if (wr_done !== e.done) begin mismatched++; $display("FAIL %s wr_done: got %b want %b", e.name, wr_done, e.done); end
      if (wr_addr_q !== e.aq) begin mismatched++; $display("FAIL %s wr_addr_q: got %0d want %0d", e.name, wr_addr_q, e.aq); end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) er[i] = '0;
    // reset held with a pending write: nothing stored
    cyc("reset0", 0, 1, 4'd5, 32'hDEADBEEF, 0, '0, 0, '0);
    cyc("reset1", 0, 1, 4'd5, 32'hDEADBEEF, 0, '0, 0, '0);
    for (int n = 0; n < 16; n++) begin
      er[n] = 32'h1000_0000 + n; ev[n] = 1'b1; ed = 1'b1; ea = 4'(n);
      cyc($sformatf("sweep%0d", n), 1, 1, 4'(n), 32'h1000_0000 + n, 0, '0, 0, '0);
    end
    ed = 1'b0;
    cyc("sweep_idle", 1, 0, 4'd2, 32'h5A5A_5A5A, 0, '0, 0, '0);
    for (int i = 0; i < 16; i++) er[i] = '0;
    ev = 0; ea = 0;
    cyc("mid_reset", 0, 1, 4'd9, 32'h1234_5678, 1, 32'h0000_0FF0, 0, '0);
    er[15] = 32'h0000_2000; ev[15] = 1'b1; ed = 1'b1; ea = 4'd15;
    cyc("pc_collide", 1, 1, 4'd15, 32'h0000_2000, 1, 32'h0000_0104, 0, '0);
    er[15] = 32'h0000_2004; ed = 1'b0;
    cyc("pc_alone", 1, 0, 4'd0, 32'hFFFF_FFFF, 1, 32'h0000_2004, 0, '0);
    er[3] = 32'hAAAA_5555; er[15] = 32'h0000_0008; ev[3] = 1'b1; ed = 1'b1; ea = 4'd3;
    cyc("parallel", 1, 1, 4'd3, 32'hAAAA_5555, 1, 32'h0000_0008, 0, '0);
    er[14] = 32'h0000_0099; ev[14] = 1'b1; ea = 4'd14;
    cyc("lr_collide", 1, 1, 4'd14, 32'h0000_0099, 0, '0, 1, 32'h0000_0044);
    ed = 1'b0;
`ifdef REG_BANK_LINK_EN
    er[14] = 32'h0000_0044;
`endif
    cyc("lr_alone", 1, 0, 4'd7, 32'h7777_7777, 0, '0, 1, 32'h0000_0044);
    er[0] = 32'hFFFF_FFFF; ev[0] = 1'b1; ed = 1'b1; ea = 4'd0;
    cyc("r0_ones", 1, 1, 4'd0, 32'hFFFF_FFFF, 0, '0, 0, '0);
    ed = 1'b0;
    cyc("final_idle", 1, 0, 4'd0, '0, 0, '0, 0, '0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/reg_bank_wr16.md
# reg_bank_wr16

Write side of the 16-entry general register bank in the multi-cycle ARM datapath. It decodes a 4-bit register address and stores write data into one of sixteen W-bit registers. It also keeps R15 (PC) updated from a dedicated fetch port and tracks which registers have been written since reset. All sixteen registers are presented in parallel on a flattened bus that feeds the 16:1 read multiplexers.

## Interface
Parameters:
- W, 32, register width in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- wr_en  in  1  general write request from the writeback state.
- wr_addr  in  4  general write register index, 0–15.
- wr_data  in  W  general write data.
- pc_wr_en  in  1  PC update request from the fetch state.
- pc_in  in  W  next PC value, normally PC+4.
- lr_wr_en  in  1  link write request for BL. Present only with REG_BANK_LINK_EN.
- lr_data  in  W  link value. Present only with REG_BANK_LINK_EN.
- regs_flat  out  16*W  register n occupies bits [n*W +: W].
- pc  out  W  copy of register 15.
- reg_valid  out  16  bit n is set once register n has been written since reset.
- wr_done  out  1  one-cycle pulse after a general-port write is accepted.
- wr_addr_q  out  4  index of the last accepted general-port write.

## Operation
- Storage is 16 × W flops. A write decoder produces one enable per register. Inputs are not combinationally bypassed to outputs.
- General port: when wr_en=1, register wr_addr ← wr_data on the edge. reg_valid[wr_addr] ← 1. wr_addr_q ← wr_addr. wr_done ← 1 for the next cycle.
- When wr_en=0, wr_done ← 0 and wr_addr_q holds its value.
- PC port: when pc_wr_en=1, register 15 ← pc_in and reg_valid[15] ← 1. This port does not affect wr_done or wr_addr_q.
- Link port (macro enabled): when lr_wr_en=1, register 14 ← lr_data and reg_valid[14] ← 1. It does not affect wr_done or wr_addr_q.
- Priority when several requests target the same register in one cycle:
  - General port beats PC port on R15, so a branch or load to PC overrides PC+4.
  - General port beats link port on R14.
  - The losing request is dropped without error.
- Writes to different registers in the same cycle (for example general → R3 while PC port → R15) all complete.
- reg_valid bits are sticky; only reset clears them.
- No arithmetic is performed; data is stored bit-exact at width W.

## Timing
- Reset values, applied on the first edge with rst_n=0: all 16 registers 0, pc 0, reg_valid 16'h0000, wr_done 0, wr_addr_q 0.
- While rst_n=0, all write requests are ignored.
- When reset is asserted in the same cycle as a write, reset wins and nothing is stored.
- Write latency is 1 cycle: data presented at edge k appears on regs_flat, pc and reg_valid just after edge k.
- wr_done is high for exactly the cycle following each accepted general write. Back-to-back writes keep it high continuously.
- Reads are combinational from the flops, so a read in the same cycle as a write returns the old value.

## Configuration
- REG_BANK_LINK_EN defined:
  - lr_wr_en and lr_data ports exist.
  - The link port writes R14 with the priority given above.
- REG_BANK_LINK_EN undefined:
  - Those ports are absent.
  - R14 is writable only through the general port.
  - All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF. Required: all regs 0, reg_valid=0, wr_done=0.
- Decode sweep: write register n with value 32'h1000_0000+n for n=0..15 on consecutive cycles. Required:
  - each value lands only in slot n;
  - wr_done stays high from the cycle after the first write through the cycle after the last;
  - reg_valid=16'hFFFF at the end.
- PC collision: in one cycle assert pc_wr_en with pc_in=32'h0000_0104 and wr_en with wr_addr=15, wr_data=32'h0000_2000. Required: pc=32'h0000_2000. On the next cycle, pc_wr_en alone with 32'h0000_2004 gives pc=32'h0000_2004.
- Parallel writes: wr_addr=3 with data 32'hAAAA_5555 and pc_wr_en with 32'h0000_0008 in the same cycle. Required: R3=32'hAAAA_5555, pc=32'h0000_0008, reg_valid[3] and reg_valid[15] both set.
- Link (macro on): lr_wr_en with 32'h0000_0044 while wr_en writes R14 with 32'h0000_0099. Required: R14=32'h0000_0099. Then lr_wr_en alone gives R14=32'h0000_0044 and wr_done=0 on that cycle.
- Reset mid-run: after the decode sweep, pulse rst_n=0 for one cycle. Required: every register 0, reg_valid=0, wr_addr_q=0 on the next cycle.
